// File: rtl/ball_ctrl_pkg.sv
// Shared types, constants and the per-axis bounce rule
// for the ball controller.
package ball_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT,
    UPD_X,
    UPD_Y,
    APPLY
  } state_t;

  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;

  localparam int RADIUS_SCALE  = 5;
  localparam int H_VISIBLE_DEF = 800;
  localparam int V_VISIBLE_DEF = 600;

  typedef struct packed {
    logic [10:0] pos;
    logic        flip;
  } axis_t;

  // One axis step: fwd means increasing coordinate.
  // hold only clamps an overlapping ball, never flips.
  function automatic axis_t axis_next(
    input logic [11:0] pos,
    input logic [11:0] r,
    input logic        fwd,
    input logic        hold,
    input logic [11:0] top,
    input logic [11:0] step
  );
    axis_t       a;
    logic [11:0] np;
    a.flip = 1'b0;
    a.pos  = pos[10:0];
    np     = pos + step;
    if (hold) begin
      if (pos + r > top) begin
        a.pos = 11'(top - r);
      end else if (pos < r) begin
        a.pos = r[10:0];
      end
    end else if (fwd) begin
      if (np + r > top) begin
        a.pos  = 11'(top - r);
        a.flip = 1'b1;
      end else begin
        a.pos = np[10:0];
      end
    end else begin
      if (pos < r + step) begin
        a.pos  = r[10:0];
        a.flip = 1'b1;
      end else begin
        a.pos = 11'(pos - step);
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// VGA timing, buttons and ball attributes between
// the display side and the ball controller.
interface ball_ctrl_if;
  logic [10:0] vcounter;
  logic [11:0] hcounter;
  logic        btn_color;
  logic        btn_size;
  logic        btn_pause;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [1:0]  color;
  logic [2:0]  radius;

  modport master (
    output vcounter, hcounter,
    output btn_color, btn_size, btn_pause,
    input  ball_x, ball_y, color, radius
  );

  modport slave (
    input  vcounter, hcounter,
    input  btn_color, btn_size, btn_pause,
    output ball_x, ball_y, color, radius
  );
endinterface

// File: rtl/ball_ctrl_btn_event.sv
// Rising-edge detector with a sticky pending flag;
// an edge in the clearing cycle survives the clear.
module btn_event (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr,
  output logic pending
);
  logic prev;
  logic rise;

  assign rise = btn & ~prev;

  // Track button history and latch edges until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= btn;
      pending <= rise | (pending & ~clr);
    end
  end
endmodule

// File: rtl/ball_ctrl.sv
// Ball position/attribute controller, updated once
// per frame during vertical blank.
module ball_ctrl
  import ball_ctrl_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int STEP      = 2
) (
  input logic       clk,
  input logic       rst,
  ball_ctrl_if.slave bus
);
  state_t state_q;
  state_t state_d;

  logic        match;
  logic        match_q;
  logic        tick;
  logic        do_x;
  logic        do_y;
  logic        do_apply;
  logic [10:0] x_q;
  logic [10:0] y_q;
  logic        dir_x;
  logic        dir_y;
  logic        paused;
  logic [1:0]  color_q;
  logic [2:0]  radius_q;
  logic [5:0]  r6;
  logic        pend_c;
  logic        pend_s;
  logic        pend_p;
  axis_t       ax;
  axis_t       ay;

  assign match = (bus.vcounter == 11'(V_VISIBLE))
              && (bus.hcounter == 12'd0);
  assign tick  = match & ~match_q;

  // Remember the match so a held counter ticks once.
  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end

  // FSM next state: tick starts a fixed 3-step walk.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:    if (tick) state_d = UPD_X;
      UPD_X:   state_d = UPD_Y;
      UPD_Y:   state_d = APPLY;
      APPLY:   state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // FSM outputs: one update strobe per state.
  always_comb begin
    do_x     = 1'b0;
    do_y     = 1'b0;
    do_apply = 1'b0;
    unique case (state_q)
      UPD_X:   do_x     = 1'b1;
      UPD_Y:   do_y     = 1'b1;
      APPLY:   do_apply = 1'b1;
      default: ;
    endcase
  end

  btn_event u_color (
    .clk(clk), .rst(rst), .btn(bus.btn_color),
    .clr(do_apply), .pending(pend_c)
  );
  btn_event u_size (
    .clk(clk), .rst(rst), .btn(bus.btn_size),
    .clr(do_apply), .pending(pend_s)
  );
  btn_event u_pause (
    .clk(clk), .rst(rst), .btn(bus.btn_pause),
    .clr(do_apply), .pending(pend_p)
  );

  assign r6 = 6'(radius_q * RADIUS_SCALE);

  assign ax = axis_next({1'b0, x_q}, {6'd0, r6},
                        dir_x, paused,
                        12'(H_VISIBLE - 1), 12'(STEP));
  assign ay = axis_next({1'b0, y_q}, {6'd0, r6},
                        dir_y, paused,
                        12'(V_VISIBLE - 1), 12'(STEP));

  // Ball state: move x, then y, then apply buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= 11'(H_VISIBLE / 2);
      y_q      <= 11'(V_VISIBLE / 2);
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      paused   <= 1'b0;
      color_q  <= COLOR_RED;
      radius_q <= 3'd1;
    end else begin
      if (do_x) begin
        x_q <= ax.pos;
        if (ax.flip) dir_x <= ~dir_x;
      end
      if (do_y) begin
        y_q <= ay.pos;
        if (ay.flip) dir_y <= ~dir_y;
      end
      if (do_apply) begin
        if (pend_c)
          color_q <= (color_q == COLOR_BLUE) ?
                     COLOR_RED : color_q + 2'd1;
        if (pend_s)
          radius_q <= (radius_q == 3'd7) ?
                      3'd1 : radius_q + 3'd1;
        if (pend_p) paused <= ~paused;
      end
    end
  end

  assign bus.ball_x = x_q;
  assign bus.ball_y = y_q;
  assign bus.color  = color_q;
  assign bus.radius = radius_q;
endmodule

// File: tb/tb_ball_ctrl.sv
// Directed plus random frames against a per-frame
// behavioural model of the ball rules.
module tb_ball_ctrl;
  import ball_ctrl_pkg::*;

  localparam int HV = 800;
  localparam int VV = 600;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int mx, my, mcol, mrad;
  bit mdx, mdy, mpause;
  bit pc, ps, pp;
  bit lc, ls, lp;

  ball_ctrl_if ifc ();

  ball_ctrl #(.H_VISIBLE(HV), .V_VISIBLE(VV),
              .STEP(ST)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = HV / 2; my = VV / 2;
    mdx = 1; mdy = 1; mpause = 0;
    mcol = 1; mrad = 1;
    pc = 0; ps = 0; pp = 0;
    lc = 0; ls = 0; lp = 0;
  endtask

  task automatic set_btn(input int k, input bit v);
    case (k)
      0: begin
        if (v && !lc) pc = 1;
        lc = v; ifc.btn_color = v;
      end
      1: begin
        if (v && !ls) ps = 1;
        ls = v; ifc.btn_size = v;
      end
      default: begin
        if (v && !lp) pp = 1;
        lp = v; ifc.btn_pause = v;
      end
    endcase
  endtask

  task automatic pulse(input int k);
    set_btn(k, 1); step();
    set_btn(k, 0); step();
  endtask

  task automatic move(inout int p, inout bit d,
                      input int top, input int r,
                      input bit hold);
    if (hold) begin
      if (p + r > top) p = top - r;
      else if (p < r) p = r;
    end else if (d) begin
      if (p + ST + r > top) begin
        p = top - r; d = 0;
      end else p = p + ST;
    end else begin
      if (p - ST < r) begin
        p = r; d = 1;
      end else p = p - ST;
    end
  endtask

  task automatic model_frame();
    int r;
    r = mrad * 5;
    move(mx, mdx, HV - 1, r, mpause);
    move(my, mdy, VV - 1, r, mpause);
    if (pc) mcol = (mcol == 3) ? 1 : mcol + 1;
    if (ps) mrad = (mrad == 7) ? 1 : mrad + 1;
    if (pp) mpause = !mpause;
    pc = 0; ps = 0; pp = 0;
  endtask

  task automatic frame(input bit apply_edge);
    int ox, oy, oc, orad;
    ox = mx; oy = my; oc = mcol; orad = mrad;
    model_frame();
    ifc.vcounter = 11'(VV);
    ifc.hcounter = 12'd0;
    step();
    ifc.hcounter = 12'd1;
    chk("x_hold", 32'(ifc.ball_x), ox);
    step();
    chk("x_upd", 32'(ifc.ball_x), mx);
    chk("y_hold", 32'(ifc.ball_y), oy);
    step();
    chk("y_upd", 32'(ifc.ball_y), my);
    chk("col_hold", 32'(ifc.color), oc);
    chk("rad_hold", 32'(ifc.radius), orad);
    if (apply_edge) set_btn(0, 1);
    step();
    chk("col_upd", 32'(ifc.color), mcol);
    chk("rad_upd", 32'(ifc.radius), mrad);
    ifc.vcounter = 11'd0;
    if (apply_edge) begin
      set_btn(0, 0);
      step();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, 32'(ifc.ball_x), HV / 2);
    chk({tag, "_y"}, 32'(ifc.ball_y), VV / 2);
    chk({tag, "_col"}, 32'(ifc.color), 1);
    chk({tag, "_rad"}, 32'(ifc.radius), 1);
    chk({tag, "_st"}, 32'(dut.state_q), 32'(WAIT));
  endtask

  initial begin
    ifc.vcounter  = 11'd0;
    ifc.hcounter  = 12'd0;
    ifc.btn_color = 1'b0;
    ifc.btn_size  = 1'b0;
    ifc.btn_pause = 1'b0;
    model_reset();
    step(); step();
    chk_reset("rst");
    rst = 1'b0;
    step();

    frame(0);
    chk("first_x", 32'(ifc.ball_x), 402);
    chk("first_y", 32'(ifc.ball_y), 302);
    step();

    pulse(0); pulse(0); pulse(0);
    frame(0);
    chk("col_once", 32'(ifc.color), 2);
    step();

    for (int i = 0; i < 7; i++) begin
      pulse(1);
      frame(0);
      step();
    end
    chk("rad_wrap", 32'(ifc.radius), 1);

    pulse(2);
    for (int i = 0; i < 3; i++) begin
      frame(0); step();
    end
    pulse(2);
    for (int i = 0; i < 2; i++) begin
      frame(0); step();
    end

    frame(1);
    frame(0);
    step();

    model_frame();
    ifc.vcounter = 11'(VV);
    ifc.hcounter = 12'd0;
    for (int i = 0; i < 8; i++) step();
    ifc.vcounter = 11'd0;
    step();
    chk("held_x", 32'(ifc.ball_x), mx);
    chk("held_y", 32'(ifc.ball_y), my);

    for (int f = 0; f < 500; f++) begin
      int idle;
      idle = $urandom_range(1, 3);
      for (int i = 0; i < idle; i++) begin
        if ($urandom_range(0, 7) == 0) pulse(0);
        if ($urandom_range(0, 9) == 0) pulse(1);
        if ($urandom_range(0, 63) == 0) pulse(2);
        step();
      end
      frame(0);
    end

    step();
    ifc.vcounter = 11'(VV);
    ifc.hcounter = 12'd0;
    step();
    ifc.hcounter = 12'd1;
    step();
    rst = 1'b1;
    step();
    chk_reset("mid");
    rst = 1'b0;
    ifc.vcounter = 11'd0;
    model_reset();
    step();
    frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
